ps2_frame_rx: RTL and testbench
===============================

PS2_FRAME_RX -- requirements
Module: ps2_frame_rx

Interface
REQ-001 SHALL have parameter TIMEOUT, default 1500: number of clk_en ticks without a PS2_CLK falling edge after which a partial frame is aborted.
REQ-002 SHALL have port clk, input, 1: system clock; all state updates on its rising edge.
REQ-003 SHALL have port RESET, input, 1: synchronous, active-high reset.
REQ-004 SHALL have port clk_en, input, 1: tick qualifier; state advances only on clk rising edges where clk_en=1.
REQ-005 SHALL have port PS2_CLK, input, 1: raw PS/2 clock pin, asynchronous.
REQ-006 SHALL have port PS2_DATA, input, 1: raw PS/2 data pin, asynchronous.
REQ-007 SHALL have port DATA, output, 8: last correctly received byte.
REQ-008 SHALL have port DONE, output, 1: one-tick strobe, new valid byte on DATA.
REQ-009 SHALL have port ERROR, output, 1: one-tick strobe, frame discarded (parity, stop or timeout).
REQ-010 SHALL have port BUSY, output, 1: high while a frame is in progress (state not IDLE).

Function
REQ-011 SHALL pass PS2_CLK and PS2_DATA through two-stage synchronisers clocked on clk_en ticks, with equal depth so the two stay aligned.
REQ-012 SHALL detect a falling edge when synchronised PS2_CLK=0 and its previous-tick value=1; every frame bit is sampled from synchronised PS2_DATA on that tick.
REQ-013 SHALL implement states IDLE, DATA, PARITY and STOP.
REQ-014 IDLE: on an edge with data=0 (start bit), go to DATA with bit count 0; an edge with data=1 SHALL be ignored, with no ERROR.
REQ-015 DATA: shift in 8 bits LSB first; after the 8th bit, go to PARITY.
REQ-016 PARITY: capture the bit, then go to STOP; the frame is good when the 8 data bits plus the parity bit have an odd number of ones.
REQ-017 STOP: sample the stop bit, then return to IDLE.
- Stop=1 and parity good: load DATA and pulse DONE.
- Otherwise: pulse ERROR and leave DATA unchanged.
REQ-018 DONE and ERROR SHALL be registered, rise on the tick that processes the stop edge, and clear on the next clk_en tick; they are never high together.
REQ-019 Latency: DONE/ERROR SHALL be high after the 3rd clk_en tick, counting the tick that first samples the stop-bit PS2_CLK low.
REQ-020 Between clk_en ticks, DONE, ERROR, DATA and BUSY SHALL hold their values.
REQ-021 Timeout counter:
- clears on every falling edge and while in IDLE;
- otherwise increments per tick, saturating.
REQ-022 When the counter reaches TIMEOUT outside IDLE, SHALL go to IDLE, pulse ERROR for one tick and leave DATA unchanged.
REQ-023 If a falling edge and timeout expiry occur on the same tick, the edge SHALL win: it is processed and the counter is cleared.
REQ-024 An edge arriving in IDLE on the tick after a timeout abort SHALL be treated as a potential start bit.
REQ-025 Back-to-back frames SHALL be accepted with no dead tick: the start edge of the next frame is accepted on the tick after STOP.

Reset
REQ-026 With RESET=1 on a clk rising edge (regardless of clk_en), SHALL set state=IDLE, bit count=0, timeout counter=0, DATA=8'h00, DONE=0, ERROR=0, BUSY=0 and synchronisers=1 (idle line).
REQ-027 RESET asserted mid-frame SHALL discard the partial frame with no DONE or ERROR; decoding restarts at the next start bit after RESET deasserts.

Verification
REQ-028 Send frame 0x1C (parity 0, stop 1) -> one DONE tick with DATA=8'h1C; ERROR=0; BUSY high from start bit to stop bit.
REQ-029 Send 0xF0 then 0x1C back-to-back -> two DONE strobes, DATA=8'hF0 then 8'h1C; no ERROR.
REQ-030 After a good 0x1C, send 0x76 with parity=1 (bad) -> ERROR one tick, DONE=0, DATA stays 8'h1C; then send 0x76 with stop=0 -> ERROR, DATA still 8'h1C.
REQ-031 Stop PS2_CLK after 4 data bits; wait TIMEOUT ticks -> ERROR one tick, BUSY=0; next full frame 0x29 -> DONE, DATA=8'h29.
REQ-032 Assert RESET for one clk after 5 bits of a frame -> all outputs zero, no strobes; following frame 0x5A -> DONE, DATA=8'h5A.
REQ-033 Hold clk_en=0 for 20 clks after DONE -> DONE stays high, and all state and outputs hold, until the next clk_en tick.

Source files
------------

// File: rtl/ps2_frame_rx.sv
// PS/2 device-to-host frame receiver: start, 8 data LSB first, odd parity, stop.
// Strobes DONE on a good byte, ERROR on parity/stop failure or an inter-edge timeout.
module ps2_frame_rx #(
    parameter int TIMEOUT = 1500
) (
    input  logic       clk,
    input  logic       RESET,
    input  logic       clk_en,
    input  logic       PS2_CLK,
    input  logic       PS2_DATA,
    output logic [7:0] DATA,
    output logic       DONE,
    output logic       ERROR,
    output logic       BUSY
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_DATA   = 2'd1;
    localparam logic [1:0] S_PARITY = 2'd2;
    localparam logic [1:0] S_STOP   = 2'd3;

    logic [1:0]    clk_sync;
    logic [1:0]    dat_sync;
    logic          clk_prev;
    logic          fall;
    logic          dat_s;
    logic [1:0]    state;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          par;
    logic [TW-1:0] tcnt;

    assign fall  = ~clk_sync[1] & clk_prev;
    assign dat_s = dat_sync[1];
    assign BUSY  = (state != S_IDLE);

    // Equal-depth synchronisers keep the sampled data aligned with the clock edge
    always_ff @(posedge clk) begin
        if (RESET) begin
            clk_sync <= 2'b11;
            dat_sync <= 2'b11;
            clk_prev <= 1'b1;
        end else if (clk_en) begin
            clk_sync <= {clk_sync[0], PS2_CLK};
            dat_sync <= {dat_sync[0], PS2_DATA};
            clk_prev <= clk_sync[1];
        end
    end

    // Frame FSM, timeout watchdog and registered result strobes
    always_ff @(posedge clk) begin
        if (RESET) begin
            state   <= S_IDLE;
            bit_cnt <= '0;
            shreg   <= '0;
            par     <= 1'b0;
            tcnt    <= '0;
            DATA    <= 8'h00;
            DONE    <= 1'b0;
            ERROR   <= 1'b0;
        end else if (clk_en) begin
            DONE  <= 1'b0;
            ERROR <= 1'b0;
            if (fall) begin
                tcnt <= '0;
                case (state)
                    S_IDLE: begin
                        if (!dat_s) begin
                            state   <= S_DATA;
                            bit_cnt <= '0;
                        end
                    end
                    S_DATA: begin
                        shreg   <= {dat_s, shreg[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7)
                            state <= S_PARITY;
                    end
                    S_PARITY: begin
                        par   <= dat_s;
                        state <= S_STOP;
                    end
                    S_STOP: begin
                        state <= S_IDLE;
                        if (dat_s && (^{shreg, par})) begin
                            DATA <= shreg;
                            DONE <= 1'b1;
                        end else begin
                            ERROR <= 1'b1;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end else if (state == S_IDLE) begin
                tcnt <= '0;
            end else if (tcnt == TMAX) begin
                state <= S_IDLE;
                ERROR <= 1'b1;
            end else begin
                tcnt <= tcnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ps2_frame_rx.sv
// Bench for ps2_frame_rx: table vectors, directed corner sequences and
// randomized frames against a frame-level reference model.
module tb_ps2_frame_rx;

    localparam int TO = 40;

    logic       clk = 1'b0;
    logic       RESET = 1'b1;
    logic       clk_en = 1'b0;
    logic       PS2_CLK = 1'b1;
    logic       PS2_DATA = 1'b1;
    logic [7:0] DATA;
    logic       DONE;
    logic       ERROR;
    logic       BUSY;

    int n_vec = 0;
    int n_bad = 0;
    int done_ticks = 0;
    int err_ticks = 0;
    int both_ticks = 0;
    int hp = 4;
    logic [7:0] dq[$];

    typedef struct {
        logic [7:0] d;
        bit         pflip;
        bit         sbad;
        int         exp_done;
        int         exp_err;
        logic [7:0] exp_data;
    } vec_t;

    vec_t tbl[6];

    always #5 clk = ~clk;

    ps2_frame_rx #(.TIMEOUT(TO)) dut (
        .clk     (clk),
        .RESET   (RESET),
        .clk_en  (clk_en),
        .PS2_CLK (PS2_CLK),
        .PS2_DATA(PS2_DATA),
        .DATA    (DATA),
        .DONE    (DONE),
        .ERROR   (ERROR),
        .BUSY    (BUSY)
    );

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // one clk_en tick followed by one idle clk; strobes observed after the tick
    task automatic tick();
        clk_en = 1'b1;
        @(posedge clk);
        #1;
        clk_en = 1'b0;
        if (DONE === 1'b1) begin
            done_ticks++;
            dq.push_back(DATA);
        end
        if (ERROR === 1'b1) err_ticks++;
        if (DONE === 1'b1 && ERROR === 1'b1) both_ticks++;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [10:0] mkframe(input logic [7:0] d,
                                            input bit pflip,
                                            input bit sbad);
        logic p;
        p = ~(^d) ^ pflip;
        return {~sbad, p, d, 1'b0};
    endfunction

    task automatic ps2_bit(input logic b);
        PS2_DATA = b;
        repeat (2) tick();
        PS2_CLK = 1'b0;
        repeat (hp) tick();
        PS2_CLK = 1'b1;
        repeat (hp) tick();
    endtask

    task automatic send_range(input logic [10:0] f, input int lo, input int hi);
        for (int i = lo; i <= hi; i++) ps2_bit(f[i]);
    endtask

    initial begin
        logic [10:0] f;
        logic [7:0]  ref_data;
        logic [7:0]  rd;
        int d0, e0, w, bad, exp_d, exp_e;
        bit pf, sb;

        tbl[0] = '{8'h1C, 1'b0, 1'b0, 1, 0, 8'h1C};
        tbl[1] = '{8'hF0, 1'b0, 1'b0, 1, 0, 8'hF0};
        tbl[2] = '{8'h1C, 1'b0, 1'b0, 1, 0, 8'h1C};
        tbl[3] = '{8'h76, 1'b1, 1'b0, 0, 1, 8'h1C};
        tbl[4] = '{8'h76, 1'b0, 1'b1, 0, 1, 8'h1C};
        tbl[5] = '{8'h29, 1'b0, 1'b0, 1, 0, 8'h29};

        repeat (3) @(posedge clk);
        #1;
        RESET = 1'b0;
        chk("rst_data", DATA, 8'h00);
        chk("rst_done", DONE, 0);
        chk("rst_error", ERROR, 0);
        chk("rst_busy", BUSY, 0);

        // idle line edge with data=1 is ignored
        e0 = err_ticks;
        ps2_bit(1'b1);
        repeat (3) tick();
        chk("idle_one_busy", BUSY, 0);
        chk("idle_one_err", err_ticks - e0, 0);

        // BUSY spans start to stop
        f = mkframe(8'h1C, 1'b0, 1'b0);
        d0 = done_ticks;
        send_range(f, 0, 0);
        chk("busy_start", BUSY, 1);
        send_range(f, 1, 9);
        chk("busy_mid", BUSY, 1);
        send_range(f, 10, 10);
        repeat (3) tick();
        chk("busy_end", BUSY, 0);
        chk("busy_frame_done", done_ticks - d0, 1);

        for (int i = 0; i < 6; i++) begin
            d0 = done_ticks;
            e0 = err_ticks;
            send_range(mkframe(tbl[i].d, tbl[i].pflip, tbl[i].sbad), 0, 10);
            repeat (4) tick();
            chk($sformatf("tbl%0d_done", i), done_ticks - d0, tbl[i].exp_done);
            chk($sformatf("tbl%0d_err", i), err_ticks - e0, tbl[i].exp_err);
            chk($sformatf("tbl%0d_data", i), DATA, tbl[i].exp_data);
        end

        // back-to-back frames
        dq.delete();
        e0 = err_ticks;
        send_range(mkframe(8'hF0, 1'b0, 1'b0), 0, 10);
        send_range(mkframe(8'h1C, 1'b0, 1'b0), 0, 10);
        repeat (4) tick();
        chk("b2b_count", dq.size(), 2);
        chk("b2b_first", dq.size() > 0 ? int'(dq[0]) : -1, 8'hF0);
        chk("b2b_second", dq.size() > 1 ? int'(dq[1]) : -1, 8'h1C);
        chk("b2b_err", err_ticks - e0, 0);

        // timeout after 4 data bits
        d0 = done_ticks;
        e0 = err_ticks;
        send_range(mkframe(8'hA5, 1'b0, 1'b0), 0, 4);
        w = 0;
        while (err_ticks == e0 && w < TO + 30) begin
            tick();
            w++;
        end
        chk("to_err", err_ticks - e0, 1);
        chk("to_not_early", (w >= TO - 8) ? 1 : 0, 1);
        chk("to_busy", BUSY, 0);
        chk("to_done", done_ticks - d0, 0);
        chk("to_data", DATA, 8'h1C);
        d0 = done_ticks;
        send_range(mkframe(8'h29, 1'b0, 1'b0), 0, 10);
        repeat (4) tick();
        chk("after_to_done", done_ticks - d0, 1);
        chk("after_to_data", DATA, 8'h29);

        // reset in the middle of a frame
        send_range(mkframe(8'h3C, 1'b0, 1'b0), 0, 5);
        RESET = 1'b1;
        @(posedge clk);
        #1;
        RESET = 1'b0;
        chk("mrst_data", DATA, 8'h00);
        chk("mrst_done", DONE, 0);
        chk("mrst_error", ERROR, 0);
        chk("mrst_busy", BUSY, 0);
        d0 = done_ticks;
        e0 = err_ticks;
        repeat (TO + 10) tick();
        chk("mrst_no_done", done_ticks - d0, 0);
        chk("mrst_no_err", err_ticks - e0, 0);
        send_range(mkframe(8'h5A, 1'b0, 1'b0), 0, 10);
        repeat (4) tick();
        chk("mrst_next_done", done_ticks - d0, 1);
        chk("mrst_next_data", DATA, 8'h5A);

        // outputs hold while clk_en stays low
        f = mkframe(8'h66, 1'b0, 1'b0);
        send_range(f, 0, 9);
        d0 = done_ticks;
        PS2_DATA = 1'b1;
        repeat (2) tick();
        PS2_CLK = 1'b0;
        w = 0;
        while (done_ticks == d0 && w < 10) begin
            tick();
            w++;
        end
        chk("hold_done_rise", done_ticks - d0, 1);
        chk("stop_latency", w, 3);
        bad = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (!(DONE === 1'b1 && DATA === 8'h66 && BUSY === 1'b0 && ERROR === 1'b0))
                bad++;
        end
        chk("hold_violations", bad, 0);
        tick();
        chk("hold_done_clear", DONE, 0);
        PS2_CLK = 1'b1;
        repeat (4) tick();

        // randomized frames against a frame-level model
        ref_data = 8'h66;
        for (int k = 0; k < 40; k++) begin
            rd = 8'($urandom);
            pf = ($urandom_range(0, 3) == 0);
            sb = ($urandom_range(0, 3) == 0);
            hp = $urandom_range(2, 6);
            exp_d = (!pf && !sb) ? 1 : 0;
            exp_e = 1 - exp_d;
            if (exp_d == 1) ref_data = rd;
            d0 = done_ticks;
            e0 = err_ticks;
            send_range(mkframe(rd, pf, sb), 0, 10);
            repeat ($urandom_range(3, 6)) tick();
            chk($sformatf("rnd%0d_done", k), done_ticks - d0, exp_d);
            chk($sformatf("rnd%0d_err", k), err_ticks - e0, exp_e);
            chk($sformatf("rnd%0d_data", k), DATA, ref_data);
        end

        chk("never_both", both_ticks, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
